mul_div_sequencer: RTL and testbench

Sequences the EX-stage multiplier and divider for MULT/MULTU/DIV/DIVU, holds the architectural HI/LO registers, and produces the EX-stage ready-go term for multi-cycle operations. Sits beside the ALU in the EX stage:
- EX presents a mul/div op and operands.
- The sequencer drives the divider handshake, times the fixed-latency multiplier and buffers the 64-bit result.
- It commits the result to HI/LO only when the pipeline advances past EX.

---
 rtl/mul_div_sequencer_if.sv | 29 ++
 rtl/mul_div_sequencer.sv | 145 ++++++++++++++
 tb/tb_mul_div_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_sequencer_if.sv
// rtl/mul_div_sequencer_if.sv - divider request/response handshake between sequencer and divider
interface mul_div_sequencer_if;
    logic        div_request_valid;
    logic        div_request_ready;
    logic        div_result_valid;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_abort;

    // sequencer side
    modport master (
        output div_request_valid,
        output div_abort,
        input  div_request_ready,
        input  div_result_valid,
        input  div_quotient,
        input  div_remainder
    );

    // divider side
    modport slave (
        input  div_request_valid,
        input  div_abort,
        output div_request_ready,
        output div_result_valid,
        output div_quotient,
        output div_remainder
    );
endinterface

// File: rtl/mul_div_sequencer.sv
// rtl/mul_div_sequencer.sv - EX-stage mul/div sequencer holding architectural HI/LO
module mul_div_sequencer #(
    parameter int MUL_LATENCY = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       op_valid,
    input  logic                       op_is_divide,
    input  logic                       pipe_advance,
    input  logic                       flush,
    input  logic [63:0]                mul_result,
    mul_div_sequencer_if.master        div_bus,
    input  logic                       move_write_high,
    input  logic                       move_write_low,
    input  logic [31:0]                move_data,
    output logic                       op_ready_go,
    output logic                       busy,
    output logic [31:0]                high_value,
    output logic [31:0]                low_value
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_WAIT,
        DIV_REQ,
        DIV_WAIT,
        DONE
    } state_t;

    // Counter starts at latency-1 so the capture lands exactly MUL_LATENCY cycles after acceptance
    localparam logic [2:0] COUNT_INIT = 3'(MUL_LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  count;
    logic [2:0]  count_next;
    logic [63:0] result_buf;
    logic [63:0] result_next;
    logic        commit;
    logic        abort_next;
    logic        div_abort_q;
    logic [31:0] high_q;
    logic [31:0] low_q;

    // Next-state, counter and result-buffer selection; flush overrides every other transition
    always_comb begin
        state_next  = state;
        count_next  = count;
        result_next = result_buf;
        commit      = 1'b0;
        abort_next  = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid && !flush) begin
                    if (op_is_divide) begin
                        state_next = DIV_REQ;
                    end else begin
                        state_next = MUL_WAIT;
                        count_next = COUNT_INIT;
                    end
                end
            end
            MUL_WAIT: begin
                if (count == 3'd0) begin
                    result_next = mul_result;
                    state_next  = DONE;
                end else begin
                    count_next = count - 3'd1;
                end
            end
            DIV_REQ: begin
                if (div_bus.div_request_ready) begin
                    if (div_bus.div_result_valid) begin
                        result_next = {div_bus.div_remainder, div_bus.div_quotient};
                        state_next  = DONE;
                    end else begin
                        state_next = DIV_WAIT;
                    end
                end
            end
            DIV_WAIT: begin
                if (div_bus.div_result_valid) begin
                    result_next = {div_bus.div_remainder, div_bus.div_quotient};
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (pipe_advance) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush && state != IDLE) begin
            state_next  = IDLE;
            count_next  = count;
            result_next = result_buf;
            commit      = 1'b0;
            abort_next  = (state == DIV_REQ) || (state == DIV_WAIT);
        end
    end

    // Sequencer state, latency counter, result buffer and registered abort pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= 3'd0;
            result_buf  <= 64'd0;
            div_abort_q <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            result_buf  <= result_next;
            div_abort_q <= abort_next;
        end
    end

    // HI/LO update: a move is the younger instruction, so it beats a same-register commit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            high_q <= 32'd0;
            low_q  <= 32'd0;
        end else begin
            if (move_write_high) begin
                high_q <= move_data;
            end else if (commit) begin
                high_q <= result_buf[63:32];
            end
            if (move_write_low) begin
                low_q <= move_data;
            end else if (commit) begin
                low_q <= result_buf[31:0];
            end
        end
    end

    assign op_ready_go               = (state == DONE);
    assign busy                      = (state != IDLE);
    assign div_bus.div_request_valid = (state == DIV_REQ);
    assign div_bus.div_abort         = div_abort_q;
    assign high_value                = high_q;
    assign low_value                 = low_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb/tb_mul_div_sequencer.sv - randomized self-checking bench for mul_div_sequencer
module tb_mul_div_sequencer;

    localparam int MUL_LATENCY = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_is_divide = 1'b0;
    logic        pipe_advance = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] mul_result = 64'd0;
    logic        move_write_high = 1'b0;
    logic        move_write_low = 1'b0;
    logic [31:0] move_data = 32'd0;
    logic        op_ready_go;
    logic        busy;
    logic [31:0] high_value;
    logic [31:0] low_value;

    mul_div_sequencer_if div_bus();

    mul_div_sequencer #(.MUL_LATENCY(MUL_LATENCY)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .op_valid        (op_valid),
        .op_is_divide    (op_is_divide),
        .pipe_advance    (pipe_advance),
        .flush           (flush),
        .mul_result      (mul_result),
        .div_bus         (div_bus),
        .move_write_high (move_write_high),
        .move_write_low  (move_write_low),
        .move_data       (move_data),
        .op_ready_go     (op_ready_go),
        .busy            (busy),
        .high_value      (high_value),
        .low_value       (low_value)
    );

    always #5 clock = ~clock;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic status(input string tag, input logic rg, input logic bs, input logic rv, input logic ab);
        check({tag, ".ready_go"}, 64'(op_ready_go), 64'(rg));
        check({tag, ".busy"}, 64'(busy), 64'(bs));
        check({tag, ".req_valid"}, 64'(div_bus.div_request_valid), 64'(rv));
        check({tag, ".abort"}, 64'(div_bus.div_abort), 64'(ab));
        check({tag, ".hi"}, 64'(high_value), 64'(exp_hi));
        check({tag, ".lo"}, 64'(low_value), 64'(exp_lo));
    endtask

    // Advance one cycle; datapath inputs get junk so only the intended cycle can be captured
    task automatic tick();
        @(posedge clock);
        #1;
        mul_result             = {$urandom, $urandom};
        div_bus.div_quotient   = $urandom;
        div_bus.div_remainder  = $urandom;
    endtask

    task automatic finish_op(input string tag, input logic [63:0] res, input int hold,
                             input logic mth, input logic mtl, input logic [31:0] md);
        for (int i = 0; i < hold; i++) begin
            status({tag, "_hold"}, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        status({tag, "_done"}, 1'b1, 1'b1, 1'b0, 1'b0);
        pipe_advance    = 1'b1;
        move_write_high = mth;
        move_write_low  = mtl;
        move_data       = md;
        tick();
        pipe_advance    = 1'b0;
        move_write_high = 1'b0;
        move_write_low  = 1'b0;
        op_valid        = 1'b0;
        exp_hi = mth ? md : res[63:32];
        exp_lo = mtl ? md : res[31:0];
        status({tag, "_commit"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_mul(input logic [63:0] prod, input int hold,
                          input logic mth, input logic mtl, input logic [31:0] md);
        op_valid     = 1'b1;
        op_is_divide = 1'b0;
        status("mul_accept", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= MUL_LATENCY; i++) begin
            if (i == MUL_LATENCY) mul_result = prod;
            status("mul_wait", 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        finish_op("mul", prod, hold, mth, mtl, md);
    endtask

    task automatic do_div(input logic [31:0] q, input logic [31:0] r, input int rdy_dly,
                          input int res_dly, input int hold,
                          input logic mth, input logic mtl, input logic [31:0] md);
        op_valid     = 1'b1;
        op_is_divide = 1'b1;
        status("div_accept", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        op_is_divide = $urandom_range(0, 1);
        for (int i = 0; i < rdy_dly; i++) begin
            status("div_req", 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        div_bus.div_request_ready = 1'b1;
        status("div_handshake", 1'b0, 1'b1, 1'b1, 1'b0);
        if (res_dly == 0) begin
            div_bus.div_result_valid = 1'b1;
            div_bus.div_quotient     = q;
            div_bus.div_remainder    = r;
            tick();
        end else begin
            tick();
            div_bus.div_request_ready = 1'b0;
            for (int i = 1; i < res_dly; i++) begin
                status("div_wait", 1'b0, 1'b1, 1'b0, 1'b0);
                tick();
            end
            status("div_wait", 1'b0, 1'b1, 1'b0, 1'b0);
            div_bus.div_result_valid = 1'b1;
            div_bus.div_quotient     = q;
            div_bus.div_remainder    = r;
            tick();
        end
        div_bus.div_request_ready = 1'b0;
        div_bus.div_result_valid  = 1'b0;
        finish_op("div", {r, q}, hold, mth, mtl, md);
    endtask

    // kind 0: flush in MUL_WAIT, 1: flush in DIV_REQ, 2: flush in DIV_WAIT
    task automatic flush_op(input int kind);
        op_valid     = 1'b1;
        op_is_divide = (kind != 0);
        status("flush_accept", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        if (kind == 2) begin
            div_bus.div_request_ready = 1'b1;
            tick();
            div_bus.div_request_ready = 1'b0;
            status("flush_divwait", 1'b0, 1'b1, 1'b0, 1'b0);
        end else begin
            status("flush_busy", 1'b0, 1'b1, kind == 1, 1'b0);
        end
        flush = 1'b1;
        if (kind != 0) begin
            div_bus.div_result_valid = $urandom_range(0, 1);
            div_bus.div_quotient     = 32'd9;
        end
        tick();
        flush                    = 1'b0;
        op_valid                 = 1'b0;
        div_bus.div_result_valid = 1'b0;
        status("flush_idle", 1'b0, 1'b0, 1'b0, kind != 0);
        tick();
        status("flush_after", 1'b0, 1'b0, 1'b0, 1'b0);
        div_bus.div_result_valid = 1'b1;
        div_bus.div_quotient     = 32'd9;
        tick();
        div_bus.div_result_valid = 1'b0;
        status("flush_late_result", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_moves();
        logic mth;
        logic mtl;
        logic [31:0] md;
        mth = $urandom_range(0, 1);
        mtl = $urandom_range(0, 1);
        md  = $urandom;
        move_write_high = mth;
        move_write_low  = mtl;
        move_data       = md;
        tick();
        move_write_high = 1'b0;
        move_write_low  = 1'b0;
        if (mth) exp_hi = md;
        if (mtl) exp_lo = md;
        status("idle_move", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        div_bus.div_request_ready = 1'b0;
        div_bus.div_result_valid  = 1'b0;
        div_bus.div_quotient      = 32'd0;
        div_bus.div_remainder     = 32'd0;
        tick();
        tick();
        status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();
        status("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        do_mul(64'h0000_0001_FFFF_FFFE, 0, 1'b0, 1'b0, 32'd0);
        check("mult_hi", 64'(high_value), 64'h1);
        check("mult_lo", 64'(low_value), 64'hFFFF_FFFE);
        do_div(32'd7, 32'd3, 2, 10, 0, 1'b0, 1'b0, 32'd0);
        check("div_hi", 64'(high_value), 64'd3);
        check("div_lo", 64'(low_value), 64'd7);
        do_mul({$urandom, $urandom}, 5, 1'b0, 1'b0, 32'd0);
        flush_op(2);
        do_mul({32'hCAFE_0001, 32'h0000_1234}, 0, 1'b0, 1'b1, 32'hAAAA_5555);
        check("mtlo_wins_lo", 64'(low_value), 64'hAAAA_5555);
        check("mtlo_hi_commit", 64'(high_value), 64'hCAFE_0001);
        flush_op(0);
        flush_op(1);

        repeat (40) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: do_mul(64'(a) * 64'(b), $urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
                1: begin
                    if (b == 32'd0) b = 32'd1;
                    do_div(a / b, a % b, $urandom_range(0, 3), $urandom_range(0, 4),
                           $urandom_range(0, 3),
                           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
                end
                2: idle_moves();
                default: flush_op($urandom_range(0, 2));
            endcase
        end

        op_valid     = 1'b1;
        op_is_divide = 1'b1;
        tick();
        div_bus.div_request_ready = 1'b1;
        tick();
        div_bus.div_request_ready = 1'b0;
        status("pre_reset_divwait", 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        status("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        op_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        status("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        do_mul(64'h0123_4567_89AB_CDEF, 1, 1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
